// File: rtl/mem_bus_master.sv
// CPU-side memory bus initiator: one request at a time, MSP430 byte lanes, word alignment.
// Optional access-fault checking is compiled in with `define MEM_FAULT_EN.
module mem_bus_master #(
  parameter int unsigned RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic        byte_en,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        fault,
  output logic [15:0] mab,
  output logic [15:0] mdb_wr,
  output logic        mw,
  output logic        bw,
  input  logic [15:0] mdb_rd
);

  typedef enum logic [1:0] {StIdle, StAddr, StWait, StResp} state_t;

  state_t      state;
  logic        req_we;
  logic        req_byte;
  logic [15:0] req_addr;
  logic [2:0]  wait_cnt;

  logic        fault_now;
  logic        rom_wr_in;
  logic [15:0] rd_fmt;

`ifdef MEM_FAULT_EN
  // Decided on the incoming request so the write strobe is never raised for ROM.
  assign rom_wr_in = we && (addr >= 16'hC000);
  assign fault_now = ((req_addr >= 16'h0400) && (req_addr <= 16'hBFFF)) ||
                     (req_we && (req_addr >= 16'hC000)) ||
                     (!req_byte && req_addr[0]);
`else
  assign rom_wr_in = 1'b0;
  assign fault_now = 1'b0;
`endif

  always_comb begin
    rd_fmt = mdb_rd;
    if (req_byte) begin
      rd_fmt = req_addr[0] ? {8'h00, mdb_rd[15:8]} : {8'h00, mdb_rd[7:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      ready    <= 1'b1;
      ack      <= 1'b0;
      fault    <= 1'b0;
      rdata    <= 16'h0000;
      mab      <= 16'h0000;
      mdb_wr   <= 16'h0000;
      mw       <= 1'b0;
      bw       <= 1'b0;
      req_we   <= 1'b0;
      req_byte <= 1'b0;
      req_addr <= 16'h0000;
      wait_cnt <= 3'd0;
    end else begin
      ack   <= 1'b0;
      fault <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req) begin
            req_we   <= we;
            req_byte <= byte_en;
            req_addr <= addr;
            mab      <= byte_en ? addr : {addr[15:1], 1'b0};
            bw       <= byte_en;
            mw       <= we && !rom_wr_in;
            mdb_wr   <= byte_en ? {wdata[7:0], wdata[7:0]} : wdata;
            ready    <= 1'b0;
            state    <= StAddr;
          end
        end
        StAddr: begin
          mw     <= 1'b0;
          mdb_wr <= 16'h0000;
          if (req_we) begin
            bw    <= 1'b0;
            ack   <= 1'b1;
            fault <= fault_now;
            state <= StResp;
          end else begin
            wait_cnt <= 3'(RD_WAIT - 1);
            state    <= StWait;
          end
        end
        StWait: begin
          if (wait_cnt == 3'd0) begin
            rdata <= fault_now ? 16'h0000 : rd_fmt;
            bw    <= 1'b0;
            ack   <= 1'b1;
            fault <= fault_now;
            state <= StResp;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        StResp: begin
          ready <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
